fb_arbiter: RTL and testbench
=============================

Name: fb_arbiter

Overview:
- Arbitrates the single-port 320x240 frame-buffer RAM between two requesters.
- Display fetch: read-only, high priority, feeds the display FIFO.
- CPU/graphics port: read and write.
- Fixed priority to display, with a starvation guard that forces a CPU slot.
- Registered RAM port; read data is returned tagged to its owner after fixed latency.

Parameters:
- ADDR_W, 17, frame-buffer word address width.
- PIX_W, 24, pixel/data width.
- FB_DEPTH, 76800, number of valid words (320*240); addresses >= FB_DEPTH are out of range.
- MAX_STARVE, 4, consecutive denied CPU-request cycles before the CPU is forced to win.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- disp_req  in  1  display read request.
- disp_addr  in  ADDR_W  display read address.
- disp_gnt  out  1  display request accepted this cycle (combinational).
- disp_rvalid  out  1  rd_data holds display read result.
- cpu_req  in  1  CPU request.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  PIX_W  CPU write data.
- cpu_gnt  out  1  CPU request accepted this cycle (combinational).
- cpu_rvalid  out  1  rd_data holds CPU read result.
- cpu_err  out  1  one-cycle pulse: granted CPU address was out of range.
- rd_data  out  PIX_W  shared read-return data.
- ram_en  out  1  RAM access enable (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_addr  out  ADDR_W  RAM address (registered).
- ram_wdata  out  PIX_W  RAM write data (registered).
- ram_rdata  in  PIX_W  RAM read data, valid one cycle after ram_en with ram_we=0.

Behaviour:
- Handshake: a transfer completes in any cycle where req && gnt. The requester holds addr, we and wdata stable while req=1 and gnt=0. It may present a new request in the next cycle, giving one access per cycle.
- Arbitration in cycle N (combinational):
  - force_cpu = (starve_cnt == MAX_STARVE).
  - cpu_gnt = cpu_req && (!disp_req || force_cpu).
  - disp_gnt = disp_req && !cpu_gnt.
  - At most one gnt is high. Both gnts are 0 while rst=1.
- starve_cnt (width clog2(MAX_STARVE+1)) updates at the edge ending cycle N:
  - cleared if cpu_gnt or !cpu_req;
  - otherwise incremented, saturating at MAX_STARVE.
- RAM stage (edge ending N):
  - ram_en = granted and in range; ram_we = cpu_gnt && cpu_we.
  - ram_addr and ram_wdata take the winner's values. ram_wdata is don't-care for reads but is driven with cpu_wdata.
  - No grant: ram_en=0, ram_we=0, ram_addr and ram_wdata hold their previous values.
- Out-of-range: display addresses are never checked. A CPU access with cpu_addr >= FB_DEPTH is still granted (the handshake completes), but:
  - ram_en=0 and ram_we=0;
  - cpu_err=1 in cycle N+1;
  - no cpu_rvalid is produced.
- Read return:
  - The owner tag {valid, is_cpu} is pipelined 2 stages alongside the access.
  - rd_data is registered from ram_rdata. disp_rvalid or cpu_rvalid is high in cycle N+2 for a read granted in cycle N.
  - Writes produce no rvalid.
  - Back-to-back grants produce back-to-back rvalids, in order.
  - rvalid has no backpressure: the requester must accept data in cycle N+2.
- Reset values:
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0;
  - disp_rvalid=0, cpu_rvalid=0, cpu_err=0, rd_data=0;
  - starve_cnt=0.
- Reset mid-operation: asserting rst clears the tag pipeline immediately, so in-flight reads are dropped with no rvalid after rst deasserts. Arbitration resumes on the first clock after deassertion.
- Simultaneous requests with starve_cnt < MAX_STARVE: display wins. Under continuous requests from both, the CPU wins exactly 1 of every MAX_STARVE+1 cycles.

Decomposition:
- Shared package fb_pkg holds:
  - FB_W=320, FB_H=240, FB_DEPTH=76800;
  - ADDR_W=17, PIX_W=24;
  - owner enum {OWN_DISP, OWN_CPU}.
- One sub-module, fb_rd_tag_pipe. It is a 2-stage valid/owner shift register with async reset, and it generates disp_rvalid and cpu_rvalid.

Test Plan:
- Reset: hold rst with both reqs high → both gnts=0 and all registered outputs 0. Deassert rst → disp_gnt=1 on the first cycle.
- Display only, 8 consecutive reads at addr 0..7 with ram_rdata = addr+0x100 → disp_gnt=1 every cycle; disp_rvalid=1 in cycles 2..9 with rd_data 0x100..0x107 in order.
- Contention, MAX_STARVE=4, both req held for 10 cycles → grant sequence D,D,D,D,C,D,D,D,D,C.
- CPU write cpu_addr=76799, data=0xABCDEF → ram_en=1, ram_we=1, ram_addr=76799 and ram_wdata=0xABCDEF next cycle; no rvalid. Repeat with cpu_addr=76800 → cpu_gnt=1, ram_en=0, cpu_err=1 pulse for one cycle.
- Interleaved reads: D(addr 5), C(addr 9), D(addr 6) → rvalids D, C, D in cycles N+2..N+4 with matching data.
- Assert rst for one cycle with 2 reads in flight → no rvalid after release, and starve_cnt restarts from 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants and types for the frame-buffer arbiter slice.
package fb_pkg;

  // Frame geometry: one word per pixel, row-major.
  localparam int FB_W     = 320;
  localparam int FB_H     = 240;
  localparam int FB_DEPTH = FB_W * FB_H;

  // Frame-buffer word address and pixel widths.
  localparam int ADDR_W = 17;
  localparam int PIX_W  = 24;

  // Read-return latency in cycles, measured from the grant cycle.
  localparam int TAG_STAGES = 2;

  // Who owns a read in flight.
  typedef enum logic {
    OWN_DISP = 1'b0,
    OWN_CPU  = 1'b1
  } owner_e;

  // Tag carried alongside each access through the read pipeline.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/fb_rd_tag_pipe.sv
// Owner-tag shift register that tracks reads in flight and raises the
// per-requester rvalid when the data reaches the shared rd_data register.
module fb_rd_tag_pipe
  import fb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  input  owner_e in_owner,
  output logic   rd_capture,
  output logic   disp_rvalid,
  output logic   cpu_rvalid
);

  rd_tag_t tag_in;

  assign tag_in = '{valid: in_valid, owner: in_owner};

  genvar gi;
  generate
    for (gi = 0; gi < TAG_STAGES; gi++) begin : g_stage
      rd_tag_t tag_reg;
      rd_tag_t tag_next;

      if (gi == 0) begin : g_head
        assign tag_next = tag_in;
      end else begin : g_tail
        assign tag_next = g_stage[gi-1].tag_reg;
      end

      // Advance the tag one stage; reset drops everything in flight at once.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tag_reg <= '0;
        end else begin
          tag_reg <= tag_next;
        end
      end
    end
  endgenerate

  // The stage before last marks the cycle in which the RAM read data is
  // sampled into rd_data; the last stage lines up with rd_data itself.
  assign rd_capture  = g_stage[TAG_STAGES-2].tag_reg.valid;
  assign disp_rvalid = g_stage[TAG_STAGES-1].tag_reg.valid &&
                       (g_stage[TAG_STAGES-1].tag_reg.owner == OWN_DISP);
  assign cpu_rvalid  = g_stage[TAG_STAGES-1].tag_reg.valid &&
                       (g_stage[TAG_STAGES-1].tag_reg.owner == OWN_CPU);

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer RAM arbiter: display fetch has fixed priority,
// the CPU port is guaranteed a slot after MAX_STARVE consecutive denials.
// The RAM port is registered; reads return on rd_data two cycles after grant.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W     = fb_pkg::ADDR_W,
  parameter int PIX_W      = fb_pkg::PIX_W,
  parameter int FB_DEPTH   = fb_pkg::FB_DEPTH,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [PIX_W-1:0]  cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic              cpu_err,
  output logic [PIX_W-1:0]  rd_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata
);

  localparam int STARVE_W = $clog2(MAX_STARVE + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);

  logic [STARVE_W-1:0] starve_cnt_reg;
  logic [STARVE_W-1:0] starve_cnt_next;
  logic                force_cpu;
  logic                cpu_in_range;

  logic                ram_en_reg,    ram_en_next;
  logic                ram_we_reg,    ram_we_next;
  logic [ADDR_W-1:0]   ram_addr_reg,  ram_addr_next;
  logic [PIX_W-1:0]    ram_wdata_reg, ram_wdata_next;
  logic                cpu_err_reg,   cpu_err_next;
  logic [PIX_W-1:0]    rd_data_reg;

  logic                tag_valid;
  owner_e              tag_owner;
  logic                rd_capture;

  // Only the CPU address is range-checked; display addresses are trusted.
  assign cpu_in_range = (32'(cpu_addr) < 32'(FB_DEPTH));

  // Grant decision, starvation counter update and next RAM-port values.
  always_comb begin
    force_cpu       = (starve_cnt_reg == STARVE_MAX);
    cpu_gnt         = 1'b0;
    disp_gnt        = 1'b0;
    starve_cnt_next = starve_cnt_reg;
    ram_en_next     = 1'b0;
    ram_we_next     = 1'b0;
    ram_addr_next   = ram_addr_reg;
    ram_wdata_next  = ram_wdata_reg;
    cpu_err_next    = 1'b0;
    tag_valid       = 1'b0;
    tag_owner       = OWN_DISP;

    if (!rst) begin
      cpu_gnt  = cpu_req && (!disp_req || force_cpu);
      disp_gnt = disp_req && !cpu_gnt;
    end

    // A CPU that is not asking, or has just been served, is not starving.
    if (cpu_gnt || !cpu_req) begin
      starve_cnt_next = '0;
    end else if (starve_cnt_reg != STARVE_MAX) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end

    if (cpu_gnt) begin
      // Out-of-range CPU accesses complete the handshake but never reach
      // the RAM; they are reported through cpu_err instead.
      ram_en_next    = cpu_in_range;
      ram_we_next    = cpu_in_range && cpu_we;
      ram_addr_next  = cpu_addr;
      ram_wdata_next = cpu_wdata;
      cpu_err_next   = !cpu_in_range;
      tag_valid      = cpu_in_range && !cpu_we;
      tag_owner      = OWN_CPU;
    end else if (disp_gnt) begin
      ram_en_next    = 1'b1;
      ram_addr_next  = disp_addr;
      ram_wdata_next = cpu_wdata;
      tag_valid      = 1'b1;
      tag_owner      = OWN_DISP;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // Registered RAM port and the one-cycle CPU range-error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_en_reg    <= 1'b0;
      ram_we_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
      cpu_err_reg   <= 1'b0;
    end else begin
      ram_en_reg    <= ram_en_next;
      ram_we_reg    <= ram_we_next;
      ram_addr_reg  <= ram_addr_next;
      ram_wdata_reg <= ram_wdata_next;
      cpu_err_reg   <= cpu_err_next;
    end
  end

  // Capture RAM read data in the cycle the access is on the RAM port, so it
  // is presented together with the owner's rvalid one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else if (rd_capture) begin
      rd_data_reg <= ram_rdata;
    end
  end

  fb_rd_tag_pipe u_tag_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (tag_valid),
    .in_owner    (tag_owner),
    .rd_capture  (rd_capture),
    .disp_rvalid (disp_rvalid),
    .cpu_rvalid  (cpu_rvalid)
  );

  assign ram_en    = ram_en_reg;
  assign ram_we    = ram_we_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_wdata = ram_wdata_reg;
  assign cpu_err   = cpu_err_reg;
  assign rd_data   = rd_data_reg;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter. The RAM model answers any address with
// addr + 0x100, sampled at the clock edge closing the cycle ram_en is high.
module tb_fb_arbiter;

  logic        clk;
  logic        rst;
  logic        disp_req;
  logic [16:0] disp_addr;
  logic        disp_gnt;
  logic        disp_rvalid;
  logic        cpu_req;
  logic        cpu_we;
  logic [16:0] cpu_addr;
  logic [23:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic        cpu_err;
  logic [23:0] rd_data;
  logic        ram_en;
  logic        ram_we;
  logic [16:0] ram_addr;
  logic [23:0] ram_wdata;
  logic [23:0] ram_rdata;

  int vectors;
  int errors;

  fb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_gnt    (disp_gnt),
    .disp_rvalid (disp_rvalid),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_gnt     (cpu_gnt),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_err     (cpu_err),
    .rd_data     (rd_data),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_rdata = {7'd0, ram_addr} + 24'h100;

  // Move to 1 time unit after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; disp_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
    disp_addr = 17'd3; cpu_addr = 17'd4; cpu_wdata = 24'h123456;
    tick(); tick(); #1;
    vectors++;
    if (disp_gnt !== 1'b0 || cpu_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_gnt: disp_gnt=%b cpu_gnt=%b required 0 0", disp_gnt, cpu_gnt);
    end
    vectors++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== '0) begin
      errors++; $display("FAIL reset_ram: en=%b we=%b addr=%0d wdata=%h required all 0", ram_en, ram_we, ram_addr, ram_wdata);
    end
    vectors++;
    if ({disp_rvalid, cpu_rvalid, cpu_err, rd_data} !== '0) begin
      errors++; $display("FAIL reset_ret: drv=%b crv=%b err=%b rd=%h required all 0", disp_rvalid, cpu_rvalid, cpu_err, rd_data);
    end
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (disp_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_release: disp_gnt=%b cpu_gnt=%b required 1 0", disp_gnt, cpu_gnt);
    end
    $display("reset: gnts held low, registers cleared, display granted on release");
    disp_req = 1'b0; cpu_req = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_display_stream();
    logic exp_rv;
    for (int k = 0; k < 12; k++) begin
      disp_req  = (k < 8);
      disp_addr = 17'(k);
      #1;
      if (k < 8) begin
        vectors++;
        if (disp_gnt !== 1'b1) begin
          errors++; $display("FAIL disp_gnt[%0d]: got %b required 1", k, disp_gnt);
        end
      end
      exp_rv = (k >= 2) && (k <= 9);
      vectors++;
      if (disp_rvalid !== exp_rv || cpu_rvalid !== 1'b0) begin
        errors++; $display("FAIL disp_rvalid[%0d]: got %b/%b required %b/0", k, disp_rvalid, cpu_rvalid, exp_rv);
      end
      if (exp_rv) begin
        vectors++;
        if (rd_data !== 24'h100 + 24'(k - 2)) begin
          errors++; $display("FAIL disp_rdata[%0d]: got %h required %h", k, rd_data, 24'h100 + 24'(k - 2));
        end
      end
      $display("display cycle %0d: gnt=%b rvalid=%b rd_data=%h", k, disp_gnt, disp_rvalid, rd_data);
      tick();
    end
  endtask

  task automatic test_contention();
    logic [9:0] exp_cpu;
    exp_cpu = 10'b10_0001_0000;
    disp_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
    disp_addr = 17'd10; cpu_addr = 17'd20;
    for (int k = 0; k < 10; k++) begin
      #1;
      vectors++;
      if (cpu_gnt !== exp_cpu[k] || disp_gnt !== !exp_cpu[k]) begin
        errors++; $display("FAIL contention[%0d]: disp_gnt=%b cpu_gnt=%b required %b %b", k, disp_gnt, cpu_gnt, !exp_cpu[k], exp_cpu[k]);
      end
      $display("contention cycle %0d: winner %s", k, cpu_gnt ? "C" : (disp_gnt ? "D" : "-"));
      tick();
    end
    disp_req = 1'b0; cpu_req = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_cpu_write();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'd76799; cpu_wdata = 24'hABCDEF;
    #1;
    vectors++;
    if (cpu_gnt !== 1'b1) begin
      errors++; $display("FAIL wr_gnt: got %b required 1", cpu_gnt);
    end
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    vectors++;
    if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 17'd76799 || ram_wdata !== 24'hABCDEF || cpu_err !== 1'b0) begin
      errors++; $display("FAIL wr_ram: en=%b we=%b addr=%0d wdata=%h err=%b required 1 1 76799 abcdef 0", ram_en, ram_we, ram_addr, ram_wdata, cpu_err);
    end
    tick();
    vectors++;
    if (cpu_rvalid !== 1'b0 || disp_rvalid !== 1'b0) begin
      errors++; $display("FAIL wr_rvalid: cpu=%b disp=%b required 0 0", cpu_rvalid, disp_rvalid);
    end
    $display("cpu write 76799: ram_en/we asserted, no rvalid");

    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'd76800; cpu_wdata = 24'h555555;
    #1;
    vectors++;
    if (cpu_gnt !== 1'b1) begin
      errors++; $display("FAIL oor_gnt: got %b required 1", cpu_gnt);
    end
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    vectors++;
    if (ram_en !== 1'b0 || ram_we !== 1'b0 || cpu_err !== 1'b1) begin
      errors++; $display("FAIL oor_ram: en=%b we=%b err=%b required 0 0 1", ram_en, ram_we, cpu_err);
    end
    tick();
    vectors++;
    if (cpu_err !== 1'b0 || cpu_rvalid !== 1'b0) begin
      errors++; $display("FAIL oor_pulse: err=%b rvalid=%b required 0 0", cpu_err, cpu_rvalid);
    end
    $display("cpu write 76800: granted, suppressed, cpu_err pulsed");
    tick();
  endtask

  task automatic test_interleaved_reads();
    logic [2:0]  exp_d, exp_c;
    logic [23:0] exp_data [3];
    exp_d = 3'b101; exp_c = 3'b010;
    exp_data[0] = 24'h105; exp_data[1] = 24'h109; exp_data[2] = 24'h106;
    for (int k = 0; k < 5; k++) begin
      disp_req  = (k == 0) || (k == 2);
      disp_addr = (k == 0) ? 17'd5 : 17'd6;
      cpu_req   = (k == 1);
      cpu_we    = 1'b0;
      cpu_addr  = 17'd9;
      #1;
      if (k < 3) begin
        vectors++;
        if (disp_gnt !== (k != 1) || cpu_gnt !== (k == 1)) begin
          errors++; $display("FAIL inter_gnt[%0d]: disp=%b cpu=%b", k, disp_gnt, cpu_gnt);
        end
      end
      if (k >= 2) begin
        vectors++;
        if (disp_rvalid !== exp_d[k-2] || cpu_rvalid !== exp_c[k-2] || rd_data !== exp_data[k-2]) begin
          errors++; $display("FAIL inter_ret[%0d]: drv=%b crv=%b rd=%h required %b %b %h", k, disp_rvalid, cpu_rvalid, rd_data, exp_d[k-2], exp_c[k-2], exp_data[k-2]);
        end
      end
      $display("interleave cycle %0d: dgnt=%b cgnt=%b drv=%b crv=%b rd=%h", k, disp_gnt, cpu_gnt, disp_rvalid, cpu_rvalid, rd_data);
      tick();
    end
    disp_req = 1'b0; cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_midop();
    logic [5:0] exp_cpu;
    exp_cpu = 6'b01_0000;
    disp_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
    disp_addr = 17'd40; cpu_addr = 17'd41;
    tick(); tick();
    rst = 1'b1;
    #1;
    vectors++;
    if (disp_gnt !== 1'b0 || cpu_gnt !== 1'b0 || disp_rvalid !== 1'b0) begin
      errors++; $display("FAIL midrst_hold: dgnt=%b cgnt=%b drv=%b required 0 0 0", disp_gnt, cpu_gnt, disp_rvalid);
    end
    tick();
    rst = 1'b0;
    for (int r = 0; r < 6; r++) begin
      #1;
      vectors++;
      if (cpu_gnt !== exp_cpu[r] || disp_gnt !== !exp_cpu[r]) begin
        errors++; $display("FAIL midrst_arb[%0d]: disp=%b cpu=%b required %b %b", r, disp_gnt, cpu_gnt, !exp_cpu[r], exp_cpu[r]);
      end
      if (r < 3) begin
        vectors++;
        if (disp_rvalid !== (r == 2) || cpu_rvalid !== 1'b0) begin
          errors++; $display("FAIL midrst_rvalid[%0d]: drv=%b crv=%b required %b 0", r, disp_rvalid, cpu_rvalid, r == 2);
        end
      end
      $display("after reset cycle %0d: dgnt=%b cgnt=%b drv=%b", r, disp_gnt, cpu_gnt, disp_rvalid);
      tick();
    end
    disp_req = 1'b0; cpu_req = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_display_stream();
    test_contention();
    test_cpu_write();
    test_interleaved_reads();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
